// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
// hex_scan_driver
// Eight-digit multiplexed seven-segment scan driver with per-frame snapshot.
// Revision 1.0
// ============================================================================
module hex_scan_driver #(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_hex0,
    input  logic [31:0] io_hex1,
    input  logic [31:0] io_hex2,
    input  logic [31:0] io_hex3,
    input  logic [31:0] io_hex4,
    input  logic [31:0] io_hex5,
    input  logic [31:0] io_hex6,
    input  logic [31:0] io_hex7,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        frame_o
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD     = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       dig;
    logic [31:0]      snap [8];
    logic [31:0]      hex_in [8];

    logic [31:0]      word;
    logic [6:0]       hex_seg;
    logic [6:0]       seg_next;
    logic             dp_next;
    logic             unused_bits;

    assign hex_in[0] = io_hex0;
    assign hex_in[1] = io_hex1;
    assign hex_in[2] = io_hex2;
    assign hex_in[3] = io_hex3;
    assign hex_in[4] = io_hex4;
    assign hex_in[5] = io_hex5;
    assign hex_in[6] = io_hex6;
    assign hex_in[7] = io_hex7;

    assign word        = snap[dig];
    assign unused_bits = ^{word[30:9], word[5]};

    // Active-low hex glyphs, segment a on bit 0
    always_comb begin
        hex_seg = 7'h7F;
        case (word[3:0])
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

    always_comb begin
        seg_next = hex_seg;
        dp_next  = ~word[4];
        if (word[31]) begin
            seg_next = ~word[6:0];
            dp_next  = ~word[7];
        end else if (word[8]) begin
            seg_next = 7'h7F;
            dp_next  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt     <= '0;
            dig     <= '0;
            an_o    <= 8'hFF;
            seg_o   <= 7'h7F;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                snap[k] <= '0;
            end
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                dig <= dig + 3'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // One coherent capture per frame so mid-frame writes never tear
            if (cnt == '0 && dig == 3'd0) begin
                for (int k = 0; k < 8; k++) begin
                    snap[k] <= hex_in[k];
                end
            end

            an_o    <= (cnt >= DEAD) ? ~(8'b1 << dig) : 8'hFF;
            seg_o   <= seg_next;
            dp_o    <= dp_next;
            frame_o <= (cnt == CNT_LAST) && (dig == 3'd7);
        end
    end

endmodule
`default_nettype wire
